// File: rtl/hazard_scoreboard_if.sv
// rtl/hazard_scoreboard_if.sv - ID-stage issue bus and scoreboard hazard outputs
interface hazard_scoreboard_if;
    logic        id_valid;
    logic [4:0]  id_rs1;
    logic [4:0]  id_rs2;
    logic        id_rs1_used;
    logic        id_rs2_used;
    logic [4:0]  id_rd;
    logic        id_rd_we;
    logic [1:0]  id_kind;
    logic        id_flush;
    logic        stall;
    logic        mdu_busy;
    logic [31:0] pending;
    logic [31:0] stall_count;

    modport master (
        output id_valid, id_rs1, id_rs2, id_rs1_used, id_rs2_used,
               id_rd, id_rd_we, id_kind, id_flush,
        input  stall, mdu_busy, pending, stall_count
    );

    modport slave (
        input  id_valid, id_rs1, id_rs2, id_rs1_used, id_rs2_used,
               id_rd, id_rd_we, id_kind, id_flush,
        output stall, mdu_busy, pending, stall_count
    );
endinterface

// File: rtl/hazard_scoreboard.sv
// rtl/hazard_scoreboard.sv - per-register forwarding countdown and decode stall generation
module hazard_scoreboard #(
    parameter int LOAD_LAT = 1,
    parameter int MDU_LAT  = 8
) (
    input  logic               clk,
    input  logic               rst,
    hazard_scoreboard_if.slave bus
);
    localparam int CW = $clog2(MDU_LAT + 1);
    localparam logic [CW-1:0] LOAD_L = CW'(LOAD_LAT);
    localparam logic [CW-1:0] MDU_L  = CW'(MDU_LAT);

    logic [CW-1:0] cnt [32];
    logic [CW-1:0] mdu_cnt;
    logic [31:0]   stall_cnt;
    logic [CW-1:0] rd_lat;
    logic          hz_rs1;
    logic          hz_rs2;
    logic          hz_mdu;
    logic          hz_waw;
    logic          stall;
    logic          issue;
    logic          is_mdu;

    always_comb begin
        rd_lat = '0;
        case (bus.id_kind)
            2'b01:   rd_lat = LOAD_L;
            2'b10:   rd_lat = MDU_L;
            default: rd_lat = '0;
        endcase
    end

    assign is_mdu = (bus.id_kind == 2'b10);
    assign hz_rs1 = bus.id_rs1_used && (bus.id_rs1 != 5'd0) && (cnt[bus.id_rs1] != '0);
    assign hz_rs2 = bus.id_rs2_used && (bus.id_rs2 != 5'd0) && (cnt[bus.id_rs2] != '0);
    assign hz_mdu = is_mdu && (mdu_cnt != '0);
    // A younger write must not become forwardable before an older in-flight one.
    assign hz_waw = bus.id_rd_we && (bus.id_rd != 5'd0) && (cnt[bus.id_rd] > rd_lat);

    assign stall = bus.id_valid && !bus.id_flush && !rst && (hz_rs1 || hz_rs2 || hz_mdu || hz_waw);
    assign issue = bus.id_valid && !bus.id_flush && !stall;

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int r = 0; r < 32; r++) cnt[r] <= '0;
            mdu_cnt   <= '0;
            stall_cnt <= '0;
        end else begin
            cnt[0] <= '0;
            for (int r = 1; r < 32; r++) begin
                if (issue && bus.id_rd_we && (bus.id_rd == 5'(r)))
                    cnt[r] <= rd_lat;
                else if (cnt[r] != '0)
                    cnt[r] <= cnt[r] - 1'b1;
            end
            if (issue && is_mdu)
                mdu_cnt <= MDU_L;
            else if (mdu_cnt != '0)
                mdu_cnt <= mdu_cnt - 1'b1;
            if (stall && (stall_cnt != 32'hFFFF_FFFF))
                stall_cnt <= stall_cnt + 32'd1;
        end
    end

    always_comb begin
        bus.pending = '0;
        for (int r = 0; r < 32; r++) bus.pending[r] = (cnt[r] != '0);
    end

    assign bus.stall       = stall;
    assign bus.mdu_busy    = (mdu_cnt != '0);
    assign bus.stall_count = stall_cnt;
endmodule

// File: tb/tb_hazard_scoreboard.sv
// tb/tb_hazard_scoreboard.sv - scoreboard bench with a timestamp reference model
module tb_hazard_scoreboard;
    localparam int LOAD_LAT = 1;
    localparam int MDU_LAT  = 8;

    logic clk = 1'b0;
    logic rst;
    hazard_scoreboard_if bus ();

    hazard_scoreboard #(.LOAD_LAT(LOAD_LAT), .MDU_LAT(MDU_LAT)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        stall;
        logic        busy;
        logic [31:0] pend;
        logic [31:0] scnt;
        int          cyc;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   passed = 0;
    bit   check_en = 0;

    // Model: absolute cycle at which each register / the MDU becomes free.
    int ready_at [32];
    int mdu_free;
    int cyc;
    int scount;

    function automatic int remaining(input int r);
        return (r != 0 && ready_at[r] > cyc) ? ready_at[r] - cyc : 0;
    endfunction

    function automatic int lat_of(input logic [1:0] k);
        return (k == 2'b01) ? LOAD_LAT : (k == 2'b10) ? MDU_LAT : 0;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req, input int c);
        checks++;
        if (act === req) passed++;
        else $display("FAIL %s cycle %0d: got %h expected %h", name, c, act, req);
    endtask

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            check("stall",       {31'd0, bus.stall},    {31'd0, e.stall}, e.cyc);
            check("mdu_busy",    {31'd0, bus.mdu_busy}, {31'd0, e.busy},  e.cyc);
            check("pending",     bus.pending,           e.pend,           e.cyc);
            check("stall_count", bus.stall_count,       e.scnt,           e.cyc);
        end
    end

    task automatic step(input logic v, input logic [4:0] rs1, input logic [4:0] rs2,
                        input logic u1, input logic u2, input logic [4:0] rd, input logic we,
                        input logic [1:0] kind, input logic fl, input logic r, output logic st);
        exp_t e;
        logic busy_m;
        bus.id_valid = v;  bus.id_rs1 = rs1;  bus.id_rs2 = rs2;
        bus.id_rs1_used = u1;  bus.id_rs2_used = u2;
        bus.id_rd = rd;  bus.id_rd_we = we;  bus.id_kind = kind;  bus.id_flush = fl;
        rst = r;
        busy_m = (mdu_free > cyc);
        st = v && !fl && !r &&
             ((u1 && remaining(rs1) > 0) || (u2 && remaining(rs2) > 0) ||
              (kind == 2'b10 && busy_m) || (we && remaining(rd) > lat_of(kind)));
        e.stall = st;  e.busy = busy_m;  e.scnt = scount;  e.cyc = cyc;
        for (int i = 0; i < 32; i++) e.pend[i] = (remaining(i) > 0);
        if (check_en) exp_q.push_back(e);
        @(posedge clk);
        if (r) begin
            for (int i = 0; i < 32; i++) ready_at[i] = 0;
            mdu_free = 0;
            scount = 0;
        end else begin
            if (st && scount != -1) scount++;
            if (v && !fl && !st) begin
                if (we && rd != 0) ready_at[rd] = cyc + 1 + lat_of(kind);
                if (kind == 2'b10) mdu_free = cyc + 1 + MDU_LAT;
            end
        end
        cyc++;
        #1;
    endtask

    // Presents the same instruction until it issues, as IF/ID hold would.
    task automatic issue(input logic [4:0] rs1, input logic [4:0] rs2, input logic u1, input logic u2,
                         input logic [4:0] rd, input logic we, input logic [1:0] kind, input logic fl);
        logic st;
        int n = 0;
        do begin
            step(1'b1, rs1, rs2, u1, u2, rd, we, kind, fl, 1'b0, st);
            n++;
        end while (st && n < 40);
        if (st) check("issue_bound", 32'd1, 32'd0, cyc);
    endtask

    task automatic idle(input int n);
        logic st;
        for (int i = 0; i < n; i++) step(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 2'b00, 1'b0, 1'b0, st);
    endtask

    initial begin
        logic st;
        for (int i = 0; i < 32; i++) ready_at[i] = 0;
        mdu_free = 0;  cyc = 0;  scount = 0;
        #1;
        step(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 2'b00, 1'b0, 1'b1, st);
        check_en = 1;
        step(1'b1, 5'd1, 5'd2, 1'b1, 1'b1, 5'd3, 1'b1, 2'b10, 1'b0, 1'b1, st);
        idle(1);
        // ALU back-to-back
        issue(5'd1, 5'd2, 1'b1, 1'b1, 5'd3, 1'b1, 2'b00, 1'b0);
        issue(5'd3, 5'd3, 1'b1, 1'b1, 5'd4, 1'b1, 2'b00, 1'b0);
        idle(2);
        // Load-use
        issue(5'd1, 5'd0, 1'b1, 1'b0, 5'd5, 1'b1, 2'b01, 1'b0);
        issue(5'd5, 5'd0, 1'b1, 1'b1, 5'd6, 1'b1, 2'b00, 1'b0);
        idle(2);
        // MDU dependency and MDU structural hazard
        issue(5'd1, 5'd2, 1'b1, 1'b1, 5'd7, 1'b1, 2'b10, 1'b0);
        issue(5'd0, 5'd0, 1'b0, 1'b0, 5'd11, 1'b1, 2'b10, 1'b0);
        issue(5'd7, 5'd11, 1'b1, 1'b1, 5'd12, 1'b1, 2'b00, 1'b0);
        idle(10);
        // WAW guard
        issue(5'd1, 5'd2, 1'b1, 1'b1, 5'd8, 1'b1, 2'b10, 1'b0);
        issue(5'd0, 5'd0, 1'b0, 1'b0, 5'd8, 1'b1, 2'b00, 1'b0);
        idle(2);
        // x0 and flush
        issue(5'd1, 5'd0, 1'b1, 1'b0, 5'd0, 1'b1, 2'b01, 1'b0);
        issue(5'd0, 5'd0, 1'b1, 1'b1, 5'd13, 1'b1, 2'b00, 1'b0);
        issue(5'd1, 5'd0, 1'b1, 1'b0, 5'd9, 1'b1, 2'b01, 1'b0);
        step(1'b1, 5'd9, 5'd0, 1'b1, 1'b0, 5'd14, 1'b1, 2'b01, 1'b1, 1'b0, st);
        idle(3);
        // Reset mid-MDU
        issue(5'd1, 5'd2, 1'b1, 1'b1, 5'd10, 1'b1, 2'b10, 1'b0);
        idle(3);
        step(1'b1, 5'd10, 5'd0, 1'b1, 1'b0, 5'd15, 1'b1, 2'b00, 1'b0, 1'b1, st);
        issue(5'd10, 5'd0, 1'b1, 1'b0, 5'd15, 1'b1, 2'b00, 1'b0);
        idle(2);
        // Randomized traffic on a small register window to provoke hazards
        for (int i = 0; i < 3000; i++) begin
            step($urandom_range(0, 3) != 0, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                 1'($urandom), 1'($urandom), 5'($urandom_range(0, 7)), 1'($urandom),
                 2'($urandom), $urandom_range(0, 9) == 0, $urandom_range(0, 199) == 0, st);
        end
        idle(2);
        if (exp_q.size() != 0) check("queue_drain", exp_q.size(), 32'd0, cyc);
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
